tqv_sprite_pixel_gen: RTL and testbench

Downstream pixel stage of the video peripheral: consumes the 640x480 timing generator's `hsync`, `vsync`, `display_on`, `hpos`, `vpos` and drives the TinyVGA PMOD byte. It renders a background colour, an optional 1-pixel frame border and one bouncing square sprite whose position advances once per frame. Colour and motion settings come from the peripheral's register block; sync is delayed to stay aligned with colour.

---
 rtl/tqv_sprite_pixel_gen.sv | 145 ++++++++++++++
 tb/tb_tqv_sprite_pixel_gen.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/tqv_sprite_pixel_gen.sv
// Pixel stage for the 640x480 video peripheral: background, optional frame border and one
// bouncing square sprite, with hsync/vsync delayed so they stay aligned with colour.
module tqv_sprite_pixel_gen #(
    parameter int SIZE     = 32,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hsync,
    input  logic        vsync,
    input  logic        display_on,
    input  logic [9:0]  hpos,
    input  logic [9:0]  vpos,
    input  logic [5:0]  bg_color,
    input  logic [5:0]  fg_color,
    input  logic        border_en,
    input  logic        move_en,
    input  logic [2:0]  speed,
    input  logic        load,
    input  logic [9:0]  load_x,
    input  logic [9:0]  load_y,
    output logic [7:0]  vga_out,
    output logic        frame_tick,
    output logic [9:0]  sprite_x,
    output logic [9:0]  sprite_y
);

    localparam logic [9:0] MAX_X  = 10'(H_ACTIVE - SIZE);
    localparam logic [9:0] MAX_Y  = 10'(V_ACTIVE - SIZE);
    localparam logic [9:0] SIZE_W = 10'(SIZE);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE - 1);

    // One axis of bounce motion; returns {new_dir, new_pos}. Sum kept in 11 bits to avoid wrap.
    function automatic logic [10:0] step_axis(input logic [9:0] pos, input logic dir,
                                              input logic [2:0] spd, input logic [9:0] lim);
        logic [10:0] sum;
        sum = {1'b0, pos} + {8'b0, spd};
        if (!dir) begin
            if (sum >= {1'b0, lim}) return {1'b1, lim};
            else                    return {1'b0, sum[9:0]};
        end else begin
            if (pos <= {7'b0, spd}) return {1'b0, 10'd0};
            else                    return {1'b1, pos - {7'b0, spd}};
        end
    endfunction

    logic [9:0]  x_q, x_d, y_q, y_d;
    logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic        vsync_d_q;
    logic        armed_q;
    logic        tick_q;
    logic        frame_event;
    logic [10:0] step_x, step_y;

    logic        disp_q, spr_q, bord_q, hs_q, vs_q;
    logic        in_sprite, on_border;
    logic [10:0] dx, dy;
    logic [5:0]  colour;
    logic [7:0]  vga_q, vga_d;

    // armed_q keeps a vsync that is already high at reset release from counting as an edge
    assign frame_event = vsync & ~vsync_d_q & armed_q;
    assign step_x      = step_axis(x_q, dir_x_q, speed, MAX_X);
    assign step_y      = step_axis(y_q, dir_y_q, speed, MAX_Y);

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        dir_x_d = dir_x_q;
        dir_y_d = dir_y_q;
        if (load) begin
            x_d = (load_x > MAX_X) ? MAX_X : load_x;
            y_d = (load_y > MAX_Y) ? MAX_Y : load_y;
        end else if (frame_event && move_en) begin
            x_d     = step_x[9:0];
            dir_x_d = step_x[10];
            y_d     = step_y[9:0];
            dir_y_d = step_y[10];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q       <= '0;
            y_q       <= '0;
            dir_x_q   <= 1'b0;
            dir_y_q   <= 1'b0;
            vsync_d_q <= 1'b0;
            armed_q   <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            dir_x_q   <= dir_x_d;
            dir_y_q   <= dir_y_d;
            vsync_d_q <= vsync;
            armed_q   <= 1'b1;
            tick_q    <= frame_event;
        end
    end

    // A borrow in the 11-bit difference means the pixel lies left of / above the sprite
    assign dx        = {1'b0, hpos} - {1'b0, x_q};
    assign dy        = {1'b0, vpos} - {1'b0, y_q};
    assign in_sprite = !dx[10] && (dx[9:0] < SIZE_W) && !dy[10] && (dy[9:0] < SIZE_W);
    assign on_border = (hpos == 10'd0) || (hpos == H_LAST) ||
                       (vpos == 10'd0) || (vpos == V_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q <= 1'b0;
            spr_q  <= 1'b0;
            bord_q <= 1'b0;
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
        end else begin
            disp_q <= display_on;
            spr_q  <= in_sprite;
            bord_q <= on_border;
            hs_q   <= hsync;
            vs_q   <= vsync;
        end
    end

    always_comb begin
        colour = bg_color;
        if (!disp_q)                  colour = 6'd0;
        else if (spr_q)               colour = fg_color;
        else if (border_en && bord_q) colour = fg_color;
        vga_d = {hs_q, colour[0], colour[2], colour[4], vs_q, colour[1], colour[3], colour[5]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vga_q <= '0;
        else        vga_q <= vga_d;
    end

    assign vga_out    = vga_q;
    assign frame_tick = tick_q;
    assign sprite_x   = x_q;
    assign sprite_y   = y_q;

endmodule

// File: tb/tb_tqv_sprite_pixel_gen.sv
// Self-checking bench for tqv_sprite_pixel_gen: directed scenarios plus randomized traffic
// compared against a behavioural model of the pixel rules and sprite motion.
module tb_tqv_sprite_pixel_gen;

    localparam int SIZE = 32;
    localparam int MAXX = 608;
    localparam int MAXY = 448;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hsync, vsync, display_on, border_en, move_en, load;
    logic [9:0] hpos, vpos, load_x, load_y;
    logic [5:0] bg_color, fg_color;
    logic [2:0] speed;
    logic [7:0] vga_out;
    logic       frame_tick;
    logic [9:0] sprite_x, sprite_y;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    int   mx, my;
    bit   mdx, mdy;
    bit   mprev_vs, mprev_valid;
    bit   mtick;
    bit   p_disp, p_spr, p_bord, p_hs, p_vs;
    logic [7:0] exp_vga;

    tqv_sprite_pixel_gen #(.SIZE(32), .H_ACTIVE(640), .V_ACTIVE(480)) dut (
        .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .display_on(display_on),
        .hpos(hpos), .vpos(vpos), .bg_color(bg_color), .fg_color(fg_color),
        .border_en(border_en), .move_en(move_en), .speed(speed), .load(load),
        .load_x(load_x), .load_y(load_y), .vga_out(vga_out), .frame_tick(frame_tick),
        .sprite_x(sprite_x), .sprite_y(sprite_y)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pack(input logic [5:0] c, input bit hs, input bit vs);
        return {hs, c[0], c[2], c[4], vs, c[1], c[3], c[5]};
    endfunction

    task automatic model_reset();
        mx = 0; my = 0; mdx = 0; mdy = 0;
        mprev_vs = 0; mprev_valid = 0; mtick = 0;
        p_disp = 0; p_spr = 0; p_bord = 0; p_hs = 0; p_vs = 0;
        exp_vga = 8'h00;
    endtask

    // Advance the model by one clock using the inputs as they stand, then let the DUT clock.
    task automatic cyc();
        int  hp, vp, sp;
        bit  ev;
        logic [5:0] c;
        c = bg_color;
        if (!p_disp)                  c = 6'd0;
        else if (p_spr)               c = fg_color;
        else if (border_en && p_bord) c = fg_color;
        exp_vga = pack(c, p_hs, p_vs);
        hp = int'(hpos); vp = int'(vpos); sp = int'(speed);
        p_disp = display_on;
        p_spr  = (hp >= mx) && (hp - mx < SIZE) && (vp >= my) && (vp - my < SIZE);
        p_bord = (hp == 0) || (hp == 639) || (vp == 0) || (vp == 479);
        p_hs = hsync; p_vs = vsync;
        ev = mprev_valid && vsync && !mprev_vs;
        if (load) begin
            mx = (int'(load_x) > MAXX) ? MAXX : int'(load_x);
            my = (int'(load_y) > MAXY) ? MAXY : int'(load_y);
        end else if (ev && move_en) begin
            if (!mdx) begin if (mx + sp >= MAXX) begin mx = MAXX; mdx = 1; end else mx += sp; end
            else      begin if (mx <= sp) begin mx = 0; mdx = 0; end else mx -= sp; end
            if (!mdy) begin if (my + sp >= MAXY) begin my = MAXY; mdy = 1; end else my += sp; end
            else      begin if (my <= sp) begin my = 0; mdy = 0; end else my -= sp; end
        end
        mtick = ev;
        mprev_vs = vsync; mprev_valid = 1;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        hsync = 0; vsync = 0; display_on = 0; border_en = 0; move_en = 0; load = 0;
        hpos = 0; vpos = 0; load_x = 0; load_y = 0; speed = 0;
        bg_color = 6'b110000; fg_color = 6'b001100;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (vga_out !== 8'h00) begin fails++; $display("[TB] FAIL reset_vga got %h want 00", vga_out); end
        tests++; if (frame_tick !== 1'b0) begin fails++; $display("[TB] FAIL reset_tick got %b want 0", frame_tick); end
        tests++; if (sprite_x !== 10'd0 || sprite_y !== 10'd0) begin fails++; $display("[TB] FAIL reset_pos got %0d,%0d want 0,0", sprite_x, sprite_y); end
        hpos = 100; vpos = 100; display_on = 1;
        cyc();
        cyc();
        tests++; if (vga_out !== 8'h11) begin fails++; $display("[TB] FAIL first_pixel got %h want 11", vga_out); end
    endtask

    task automatic test_load_window();
        int px[5] = '{215, 232, 199, 215, 231};
        int py[5] = '{165, 165, 165, 182, 181};
        bit fg[5] = '{1, 0, 0, 0, 1};
        logic [7:0] want;
        load_x = 200; load_y = 150; load = 1; cyc(); load = 0;
        tests++; if (sprite_x !== 10'd200 || sprite_y !== 10'd150) begin fails++; $display("[TB] FAIL load_pos got %0d,%0d want 200,150", sprite_x, sprite_y); end
        for (int i = 0; i < 5; i++) begin
            hpos = 10'(px[i]); vpos = 10'(py[i]);
            cyc(); cyc();
            want = fg[i] ? pack(fg_color, 0, 0) : pack(bg_color, 0, 0);
            tests++; if (vga_out !== want) begin fails++; $display("[TB] FAIL window(%0d,%0d) got %h want %h", px[i], py[i], vga_out, want); end
        end
    endtask

    task automatic test_load_clamp();
        load_x = 700; load_y = 999; load = 1; cyc(); load = 0;
        tests++; if (sprite_x !== 10'd608 || sprite_y !== 10'd448) begin fails++; $display("[TB] FAIL clamp got %0d,%0d want 608,448", sprite_x, sprite_y); end
        vsync = 0; cyc();
        vsync = 1; load = 1; load_x = 100; load_y = 50; move_en = 1; speed = 3;
        cyc(); load = 0;
        tests++; if (sprite_x !== 10'd100 || sprite_y !== 10'd50) begin fails++; $display("[TB] FAIL load_vs_frame got %0d,%0d want 100,50", sprite_x, sprite_y); end
        tests++; if (frame_tick !== 1'b1) begin fails++; $display("[TB] FAIL load_vs_tick got %b want 1", frame_tick); end
        cyc();
        tests++; if (frame_tick !== 1'b0 || sprite_x !== 10'd100) begin fails++; $display("[TB] FAIL tick_single got %b x=%0d want 0 x=100", frame_tick, sprite_x); end
    endtask

    task automatic test_bounce();
        int expx[7] = '{605, 608, 603, 0, 5, 608, 607};
        int expy[7] = '{105, 110, 115, 105, 110, 100, 101};
        do_reset();
        move_en = 1; speed = 5;
        load_x = 600; load_y = 100; load = 1; cyc(); load = 0;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) begin load_x = 3; load_y = 100; load = 1; cyc(); load = 0; end
            if (i == 5) begin load_x = 608; load_y = 100; load = 1; speed = 0; cyc(); load = 0; end
            if (i == 6) speed = 1;
            vsync = 0; cyc();
            vsync = 1; cyc();
            tests++; if (sprite_x !== 10'(expx[i]) || sprite_y !== 10'(expy[i])) begin fails++; $display("[TB] FAIL bounce%0d got %0d,%0d want %0d,%0d", i, sprite_x, sprite_y, expx[i], expy[i]); end
            tests++; if (frame_tick !== 1'b1) begin fails++; $display("[TB] FAIL bounce_tick%0d got %b want 1", i, frame_tick); end
        end
    endtask

    task automatic test_border();
        int px[5] = '{0, 639, 10, 10, 0};
        int py[5] = '{10, 10, 479, 10, 10};
        bit be[5] = '{1, 1, 1, 1, 0};
        bit fg[5] = '{1, 1, 1, 0, 0};
        logic [7:0] want;
        move_en = 0; vsync = 0; hsync = 0; display_on = 1;
        load_x = 300; load_y = 200; load = 1; cyc(); load = 0;
        for (int i = 0; i < 5; i++) begin
            border_en = be[i]; hpos = 10'(px[i]); vpos = 10'(py[i]);
            cyc(); cyc();
            want = fg[i] ? pack(fg_color, 0, 0) : pack(bg_color, 0, 0);
            tests++; if (vga_out !== want) begin fails++; $display("[TB] FAIL border(%0d,%0d) got %h want %h", px[i], py[i], vga_out, want); end
        end
        display_on = 0; hsync = 1;
        cyc();
        tests++; if (vga_out[7] !== 1'b0) begin fails++; $display("[TB] FAIL hsync_early got %b want 0", vga_out[7]); end
        cyc();
        tests++; if (vga_out !== 8'h80) begin fails++; $display("[TB] FAIL blank_hsync got %h want 80", vga_out); end
        vsync = 1; cyc(); cyc();
        tests++; if (vga_out !== 8'h88) begin fails++; $display("[TB] FAIL blank_syncs got %h want 88", vga_out); end
        hsync = 0; vsync = 0; display_on = 1; border_en = 0;
        cyc(); cyc();
    endtask

    task automatic test_async_reset();
        load_x = 300; load_y = 200; load = 1; cyc(); load = 0;
        hpos = 310; vpos = 210; display_on = 1;
        cyc(); cyc();
        tests++; if (vga_out !== pack(fg_color, 0, 0)) begin fails++; $display("[TB] FAIL pre_reset got %h want %h", vga_out, pack(fg_color, 0, 0)); end
        #3 rst_n = 1'b0;
        #1;
        tests++; if (vga_out !== 8'h00) begin fails++; $display("[TB] FAIL async_vga got %h want 00", vga_out); end
        tests++; if (sprite_x !== 10'd0 || sprite_y !== 10'd0) begin fails++; $display("[TB] FAIL async_pos got %0d,%0d want 0,0", sprite_x, sprite_y); end
        model_reset();
        vsync = 1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            tests++; if (frame_tick !== 1'b0) begin fails++; $display("[TB] FAIL no_tick_after_reset%0d got %b want 0", i, frame_tick); end
        end
        vsync = 0; cyc();
        vsync = 1; cyc();
        tests++; if (frame_tick !== 1'b1) begin fails++; $display("[TB] FAIL tick_after_reset got %b want 1", frame_tick); end
    endtask

    task automatic test_random();
        int v;
        move_en = 1; speed = 3'(1 + $urandom_range(0, 6));
        for (int n = 0; n < 4000; n++) begin
            display_on = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 1) == 1) begin
                v = mx + int'($urandom_range(0, 40)) - 4; if (v < 0) v = 0;
                hpos = 10'(v);
                v = my + int'($urandom_range(0, 40)) - 4; if (v < 0) v = 0;
                vpos = 10'(v);
            end else begin
                hpos = ($urandom_range(0, 9) == 0) ? 10'd639 : 10'($urandom_range(0, 639));
                vpos = ($urandom_range(0, 9) == 0) ? 10'd0 : 10'($urandom_range(0, 479));
            end
            if ($urandom_range(0, 19) == 0) vsync = ~vsync;
            if ($urandom_range(0, 9) == 0) hsync = ~hsync;
            load = ($urandom_range(0, 99) == 0);
            load_x = 10'($urandom_range(0, 1023));
            load_y = 10'($urandom_range(0, 1023));
            if ($urandom_range(0, 49) == 0) speed = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 79) == 0) move_en = ~move_en;
            if ($urandom_range(0, 49) == 0) border_en = ~border_en;
            if ($urandom_range(0, 29) == 0) bg_color = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 29) == 0) fg_color = 6'($urandom_range(0, 63));
            cyc();
            tests++; if (vga_out !== exp_vga) begin fails++; $display("[TB] FAIL rnd_vga@%0d got %h want %h", n, vga_out, exp_vga); end
            tests++; if (frame_tick !== mtick) begin fails++; $display("[TB] FAIL rnd_tick@%0d got %b want %b", n, frame_tick, mtick); end
            tests++; if (sprite_x !== 10'(mx) || sprite_y !== 10'(my)) begin fails++; $display("[TB] FAIL rnd_pos@%0d got %0d,%0d want %0d,%0d", n, sprite_x, sprite_y, mx, my); end
        end
        load = 0;
    endtask

    initial begin
        test_reset();
        test_load_window();
        test_load_clamp();
        test_bounce();
        test_border();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
